// File: rtl/ex_stage.sv
// LC-3b execute stage: operand forwarding, B-operand select, ALU and target adder,
// plus the EX/MEM pipeline register with valid/stall/flush handling.
module ex_stage #(
    parameter bit FWD_EN = 1'b1,
    parameter int WIDTH  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] sr1_in,
    input  logic [WIDTH-1:0] sr2_in,
    input  logic [2:0]       src1_in,
    input  logic [2:0]       src2_in,
    input  logic [2:0]       dest_in,
    input  logic [WIDTH-1:0] sext5_in,
    input  logic [WIDTH-1:0] sext6_in,
    input  logic [WIDTH-1:0] adj6_in,
    input  logic [WIDTH-1:0] adj9_in,
    input  logic [WIDTH-1:0] adj11_in,
    input  logic [2:0]       alu_op,
    input  logic [1:0]       bmux_sel,
    input  logic             tgt_sel,
    input  logic             reg_write_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic             wb_fwd_en,
    input  logic [2:0]       wb_fwd_dest,
    input  logic [WIDTH-1:0] wb_fwd_data,
    input  logic             mem_stall,
    input  logic             flush,
    output logic             ex_stall,
    output logic             exm_valid,
    output logic [WIDTH-1:0] exm_pc,
    output logic [WIDTH-1:0] exm_alu,
    output logic [WIDTH-1:0] exm_target,
    output logic [WIDTH-1:0] exm_store_data,
    output logic [2:0]       exm_dest,
    output logic             exm_reg_write,
    output logic             exm_mem_read,
    output logic             exm_mem_write
);

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_AND   = 3'd1,
        OP_NOT   = 3'd2,
        OP_PASSA = 3'd3,
        OP_PASSB = 3'd4,
        OP_SLL   = 3'd5,
        OP_SRL   = 3'd6,
        OP_SRA   = 3'd7
    } alu_op_e;

    logic             ex_fwd_ok_s;
    logic [WIDTH-1:0] opa_s;
    logic [WIDTH-1:0] fwd2_s;
    logic [WIDTH-1:0] opb_s;
    logic [WIDTH-1:0] alu_s;
    logic [WIDTH-1:0] target_s;
    logic [3:0]       shamt_s;

    // A load in EX/MEM has no data yet, so it never sources a forward.
    assign ex_fwd_ok_s = exm_valid & exm_reg_write & ~exm_mem_read;
    assign ex_stall    = mem_stall;

    // Source 1 forwarding: EX/MEM beats WB beats register file.
    always_comb begin
        opa_s = sr1_in;
        if (FWD_EN && ex_fwd_ok_s && (exm_dest == src1_in)) begin
            opa_s = exm_alu;
        end else if (FWD_EN && wb_fwd_en && (wb_fwd_dest == src1_in)) begin
            opa_s = wb_fwd_data;
        end else begin
            opa_s = sr1_in;
        end
    end

    // Source 2 forwarding, same priority; also feeds the store data.
    always_comb begin
        fwd2_s = sr2_in;
        if (FWD_EN && ex_fwd_ok_s && (exm_dest == src2_in)) begin
            fwd2_s = exm_alu;
        end else if (FWD_EN && wb_fwd_en && (wb_fwd_dest == src2_in)) begin
            fwd2_s = wb_fwd_data;
        end else begin
            fwd2_s = sr2_in;
        end
    end

    // B operand select.
    always_comb begin
        opb_s = fwd2_s;
        case (bmux_sel)
            2'd0:    opb_s = fwd2_s;
            2'd1:    opb_s = sext5_in;
            2'd2:    opb_s = sext6_in;
            2'd3:    opb_s = adj6_in;
            default: opb_s = fwd2_s;
        endcase
    end

    assign shamt_s  = opb_s[3:0];
    assign target_s = pc_in + (tgt_sel ? adj11_in : adj9_in);

    // ALU.
    always_comb begin
        alu_s = {WIDTH{1'b0}};
        case (alu_op_e'(alu_op))
            OP_ADD:   alu_s = opa_s + opb_s;
            OP_AND:   alu_s = opa_s & opb_s;
            OP_NOT:   alu_s = ~opa_s;
            OP_PASSA: alu_s = opa_s;
            OP_PASSB: alu_s = opb_s;
            OP_SLL:   alu_s = opa_s << shamt_s;
            OP_SRL:   alu_s = opa_s >> shamt_s;
            OP_SRA:   alu_s = $unsigned($signed(opa_s) >>> shamt_s);
            default:  alu_s = {WIDTH{1'b0}};
        endcase
    end

    // EX/MEM register: reset clears, stall holds, flush/idle loads a zeroed bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            exm_valid      <= 1'b0;
            exm_pc         <= {WIDTH{1'b0}};
            exm_alu        <= {WIDTH{1'b0}};
            exm_target     <= {WIDTH{1'b0}};
            exm_store_data <= {WIDTH{1'b0}};
            exm_dest       <= 3'd0;
            exm_reg_write  <= 1'b0;
            exm_mem_read   <= 1'b0;
            exm_mem_write  <= 1'b0;
        end else if (!mem_stall) begin
            if (flush || !id_valid) begin
                exm_valid      <= 1'b0;
                exm_pc         <= {WIDTH{1'b0}};
                exm_alu        <= {WIDTH{1'b0}};
                exm_target     <= {WIDTH{1'b0}};
                exm_store_data <= {WIDTH{1'b0}};
                exm_dest       <= 3'd0;
                exm_reg_write  <= 1'b0;
                exm_mem_read   <= 1'b0;
                exm_mem_write  <= 1'b0;
            end else begin
                exm_valid      <= 1'b1;
                exm_pc         <= pc_in;
                exm_alu        <= alu_s;
                exm_target     <= target_s;
                exm_store_data <= fwd2_s;
                exm_dest       <= dest_in;
                exm_reg_write  <= reg_write_in;
                exm_mem_read   <= mem_read_in;
                exm_mem_write  <= mem_write_in;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: two instances (forwarding on / off) driven with
// identical directed and random stimulus, checked against an arithmetic reference model.
module tb_ex_stage;

    typedef struct packed {
        logic        rst_n;
        logic        id_valid;
        logic [15:0] pc, sr1, sr2;
        logic [2:0]  src1, src2, dest;
        logic [15:0] sext5, sext6, adj6, adj9, adj11;
        logic [2:0]  op;
        logic [1:0]  bsel;
        logic        tsel, rw, mr, mw, wb_en;
        logic [2:0]  wb_dest;
        logic [15:0] wb_data;
        logic        stall, flush;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] pc, alu, target, store;
        logic [2:0]  dest;
        logic        rw, mr, mw;
    } exm_t;

    typedef struct packed {
        exm_t e;
        logic full;
    } exp_t;

    logic clk = 1'b0;
    logic reset, id_valid, tgt_sel, reg_write_in, mem_read_in, mem_write_in;
    logic wb_fwd_en, mem_stall, flush;
    logic [15:0] pc_in, sr1_in, sr2_in, sext5_in, sext6_in, adj6_in, adj9_in, adj11_in, wb_fwd_data;
    logic [2:0] src1_in, src2_in, dest_in, alu_op, wb_fwd_dest;
    logic [1:0] bmux_sel;

    logic st1, v1, rw1, mr1, mw1, st0, v0, rw0, mr0, mw0;
    logic [15:0] pc1, alu1, tg1, sd1, pc0, alu0, tg0, sd0;
    logic [2:0] ds1, ds0;
    exm_t act1, act0;

    int total = 0;
    int bad = 0;
    exp_t q1[$];
    exp_t q0[$];
    exm_t m1, m0;

    always #5 clk = ~clk;

    ex_stage #(.FWD_EN(1'b1), .WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .pc_in(pc_in), .sr1_in(sr1_in),
        .sr2_in(sr2_in), .src1_in(src1_in), .src2_in(src2_in), .dest_in(dest_in),
        .sext5_in(sext5_in), .sext6_in(sext6_in), .adj6_in(adj6_in), .adj9_in(adj9_in),
        .adj11_in(adj11_in), .alu_op(alu_op), .bmux_sel(bmux_sel), .tgt_sel(tgt_sel),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_dest(wb_fwd_dest), .wb_fwd_data(wb_fwd_data),
        .mem_stall(mem_stall), .flush(flush), .ex_stall(st1), .exm_valid(v1), .exm_pc(pc1),
        .exm_alu(alu1), .exm_target(tg1), .exm_store_data(sd1), .exm_dest(ds1),
        .exm_reg_write(rw1), .exm_mem_read(mr1), .exm_mem_write(mw1)
    );

    ex_stage #(.FWD_EN(1'b0), .WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .pc_in(pc_in), .sr1_in(sr1_in),
        .sr2_in(sr2_in), .src1_in(src1_in), .src2_in(src2_in), .dest_in(dest_in),
        .sext5_in(sext5_in), .sext6_in(sext6_in), .adj6_in(adj6_in), .adj9_in(adj9_in),
        .adj11_in(adj11_in), .alu_op(alu_op), .bmux_sel(bmux_sel), .tgt_sel(tgt_sel),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_dest(wb_fwd_dest), .wb_fwd_data(wb_fwd_data),
        .mem_stall(mem_stall), .flush(flush), .ex_stall(st0), .exm_valid(v0), .exm_pc(pc0),
        .exm_alu(alu0), .exm_target(tg0), .exm_store_data(sd0), .exm_dest(ds0),
        .exm_reg_write(rw0), .exm_mem_read(mr0), .exm_mem_write(mw0)
    );

    assign act1 = {v1, pc1, alu1, tg1, sd1, ds1, rw1, mr1, mw1};
    assign act0 = {v0, pc0, alu0, tg0, sd0, ds0, rw0, mr0, mw0};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: value seen for a source register given the last issued instruction and WB.
    function automatic logic [15:0] ref_src(input exm_t cur, input stim_t s, input logic [2:0] idx,
                                            input logic [15:0] rf, input bit fwd);
        if (fwd && cur.valid && cur.rw && !cur.mr && cur.dest == idx) return cur.alu;
        if (fwd && s.wb_en && s.wb_dest == idx) return s.wb_data;
        return rf;
    endfunction

    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int unsigned ua = a;
        int unsigned ub = b;
        int unsigned p = 1 << b[3:0];
        int sa;
        case (op)
            3'd0: return 16'((ua + ub) % 65536);
            3'd1: return a & b;
            3'd2: return 16'(65535 - ua);
            3'd3: return a;
            3'd4: return b;
            3'd5: return 16'((ua * p) % 65536);
            3'd6: return 16'(ua / p);
            3'd7: begin
                sa = a[15] ? int'(ua) - 65536 : int'(ua);
                if (sa < 0) sa = (sa - int'(p) + 1) / int'(p);
                else sa = sa / int'(p);
                return 16'(sa);
            end
            default: return 16'h0000;
        endcase
    endfunction

    function automatic exm_t model_next(input exm_t cur, input stim_t s, input bit fwd);
        exm_t n;
        logic [15:0] a, f2, b;
        n = '0;
        if (!s.rst_n) return n;
        if (s.stall) return cur;
        if (s.flush || !s.id_valid) return n;
        a  = ref_src(cur, s, s.src1, s.sr1, fwd);
        f2 = ref_src(cur, s, s.src2, s.sr2, fwd);
        b  = (s.bsel == 2'd0) ? f2 : (s.bsel == 2'd1) ? s.sext5 : (s.bsel == 2'd2) ? s.sext6 : s.adj6;
        n.valid  = 1'b1;
        n.pc     = s.pc;
        n.alu    = ref_alu(s.op, a, b);
        n.target = 16'((int'(s.pc) + int'(s.tsel ? s.adj11 : s.adj9)) % 65536);
        n.store  = f2;
        n.dest   = s.dest;
        n.rw     = s.rw;
        n.mr     = s.mr;
        n.mw     = s.mw;
        return n;
    endfunction

    function automatic stim_t base();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        s.id_valid = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        s.rst_n    = ($urandom_range(0, 49) != 0);
        s.id_valid = ($urandom_range(0, 9) != 0);
        s.stall    = ($urandom_range(0, 4) == 0);
        s.flush    = ($urandom_range(0, 9) == 0);
        s.sext5    = {{11{s.sext5[4]}}, s.sext5[4:0]};
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t x;
        @(negedge clk);
        reset = s.rst_n; id_valid = s.id_valid; pc_in = s.pc; sr1_in = s.sr1; sr2_in = s.sr2;
        src1_in = s.src1; src2_in = s.src2; dest_in = s.dest; sext5_in = s.sext5;
        sext6_in = s.sext6; adj6_in = s.adj6; adj9_in = s.adj9; adj11_in = s.adj11;
        alu_op = s.op; bmux_sel = s.bsel; tgt_sel = s.tsel; reg_write_in = s.rw;
        mem_read_in = s.mr; mem_write_in = s.mw; wb_fwd_en = s.wb_en; wb_fwd_dest = s.wb_dest;
        wb_fwd_data = s.wb_data; mem_stall = s.stall; flush = s.flush;
        m1 = model_next(m1, s, 1'b1);
        m0 = model_next(m0, s, 1'b0);
        x.e = m1; x.full = !s.rst_n || m1.valid; q1.push_back(x);
        x.e = m0; x.full = !s.rst_n || m0.valid; q0.push_back(x);
        #1;
        chk("ex_stall_fwd1", {15'd0, st1}, {15'd0, s.stall});
        chk("ex_stall_fwd0", {15'd0, st0}, {15'd0, s.stall});
    endtask

    task automatic cmp(input string tag, input exm_t a, input exp_t x);
        chk({tag, ".valid"}, {15'd0, a.valid}, {15'd0, x.e.valid});
        chk({tag, ".reg_write"}, {15'd0, a.rw}, {15'd0, x.e.rw});
        chk({tag, ".mem_read"}, {15'd0, a.mr}, {15'd0, x.e.mr});
        chk({tag, ".mem_write"}, {15'd0, a.mw}, {15'd0, x.e.mw});
        if (x.full) begin
            chk({tag, ".pc"}, a.pc, x.e.pc);
            chk({tag, ".alu"}, a.alu, x.e.alu);
            chk({tag, ".target"}, a.target, x.e.target);
            chk({tag, ".store_data"}, a.store, x.e.store);
            chk({tag, ".dest"}, {13'd0, a.dest}, {13'd0, x.e.dest});
        end
    endtask

    // Monitor: after each edge, pop the expected EX/MEM contents and compare.
    always @(posedge clk) begin
        #1;
        if (q1.size() > 0) cmp("fwd1", act1, q1.pop_front());
        if (q0.size() > 0) cmp("fwd0", act0, q0.pop_front());
    end

    initial begin
        stim_t s;
        m1 = '0;
        m0 = '0;

        s = base(); s.rst_n = 1'b0; s.stall = 1'b1; s.sr1 = 16'h5555; s.pc = 16'h1234;
        step(s); step(s);

        s = base(); s.op = 3'd0; s.sr1 = 16'h7FFF; s.src1 = 3'd2; s.bsel = 2'd1;
        s.sext5 = 16'h0001; s.dest = 3'd1; s.rw = 1'b1;
        step(s);

        s = base(); s.src1 = 3'd4; s.src2 = 3'd4; s.sr1 = 16'h000F; s.bsel = 2'd1;
        s.sext5 = 16'h0001; s.dest = 3'd3; s.rw = 1'b1;
        step(s);
        s = base(); s.src1 = 3'd3; s.src2 = 3'd3; s.sr1 = 16'h0000; s.bsel = 2'd1;
        s.sext5 = 16'h0001; s.dest = 3'd6; s.rw = 1'b1; s.wb_en = 1'b1; s.wb_dest = 3'd3;
        s.wb_data = 16'h00AA;
        step(s);

        s = base(); s.src1 = 3'd5; s.src2 = 3'd5; s.sr1 = 16'h0100; s.bsel = 2'd2;
        s.sext6 = 16'h0002; s.dest = 3'd2; s.rw = 1'b1; s.mr = 1'b1;
        step(s);
        s = base(); s.op = 3'd3; s.src1 = 3'd2; s.sr1 = 16'h1234; s.dest = 3'd4; s.rw = 1'b1;
        step(s);

        for (int i = 0; i < 3; i++) begin
            s = rand_stim(); s.rst_n = 1'b1; s.stall = 1'b1;
            step(s);
        end
        s = base(); s.op = 3'd4; s.bsel = 2'd3; s.adj6 = 16'h0C0C; s.pc = 16'h3000;
        s.dest = 3'd7; s.rw = 1'b1;
        step(s);

        s = base(); s.mw = 1'b1; s.src2 = 3'd1; s.sr2 = 16'hBEEF; s.flush = 1'b1;
        step(s);

        s = base(); s.op = 3'd7; s.src1 = 3'd0; s.sr1 = 16'h8000; s.bsel = 2'd1; s.sext5 = 16'h0004;
        step(s);
        s = base(); s.op = 3'd5; s.src1 = 3'd0; s.sr1 = 16'h0001; s.bsel = 2'd1; s.sext5 = 16'h000F;
        step(s);
        s = base(); s.pc = 16'hFFFE; s.adj9 = 16'h0004; s.adj11 = 16'h0700; s.tsel = 1'b0;
        step(s);
        s.tsel = 1'b1;
        step(s);

        for (int i = 0; i < 400; i++) begin
            step(rand_stim());
        end

        for (int i = 0; i < 5 && (q1.size() + q0.size()) > 0; i++) @(posedge clk);
        #2;
        chk("scoreboard_drained", 16'(q1.size() + q0.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
